sum8_scheduler: RTL and testbench
=================================

SUM8_SCHEDULER -- requirements
Module: sum8_scheduler

Interface
REQ-001 The block SHALL have parameter FIXED_PRIO, default 0: 0 selects round-robin arbitration; 1 makes requester 0 always win.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have ports req0 and req1, input, 1 bit each: addition request from requester 0 or 1.
REQ-005 The block SHALL have ports a0, b0, a1, b1, input, 8 bits each: operands of requester 0 and requester 1.
REQ-006 The block SHALL have ports gnt0 and gnt1, output, 1 bit each: one-cycle grant pulse; operands are sampled in this cycle.
REQ-007 The block SHALL have port res_valid, output, 1 bit: result available.
REQ-008 The block SHALL have port res_ready, input, 1 bit: consumer accepts the result.
REQ-009 The block SHALL have port res_id, output, 1 bit: index of the requester that owns the result.
REQ-010 The block SHALL have ports res_sum, output, 8 bits, and res_co, output, 1 bit: 8-bit sum and carry-out.
REQ-011 The block SHALL have ports add_n1 and add_n2, output, 4 bits each: operands driven to the shared external 4-bit adder, which has no carry-in.
REQ-012 The block SHALL have ports add_so, input, 4 bits, and add_co, input, 1 bit: combinational sum and carry returned by that adder in the same cycle.

Function
REQ-013 The FSM SHALL have the states IDLE, LO, HI, INC and DONE, one adder pass per LO, HI and INC cycle.
REQ-014 In IDLE with req0 or req1 high, the block SHALL assert the matching gnt for one cycle, latch that requester's a, b and id, and go to LO.
REQ-015 Arbitration when req0 and req1 are both high SHALL be as follows: with FIXED_PRIO=0, grant the requester not served last; with FIXED_PRIO=1, grant req0.
REQ-016 The round-robin last-served pointer SHALL update only on a grant.
REQ-017 LO SHALL drive add_n1=a[3:0] and add_n2=b[3:0], capture add_so into sum[3:0] and add_co into c_lo, then go to HI.
REQ-018 HI SHALL drive a[7:4] and b[7:4], capture add_so into sum[7:4] and add_co into c_hi, then go to INC if c_lo=1, else to DONE with res_co=c_hi.
REQ-019 INC SHALL drive add_n1=sum[7:4] and add_n2=4'b0001, capture add_so into sum[7:4], set res_co=c_hi OR add_co, then go to DONE.
REQ-020 res_sum and res_co SHALL equal (a+b) mod 256 and bit 8 of a+b for all 65536 operand pairs.
REQ-021 In IDLE and DONE, add_n1 and add_n2 SHALL be driven to 0.
REQ-022 DONE SHALL hold res_valid=1 with stable res_sum, res_co and res_id until a cycle where res_ready=1, then go to IDLE with res_valid=0 in the next cycle.
REQ-023 Latency SHALL be as follows: res_valid rises 3 cycles after the grant cycle when c_lo=0 and 4 cycles after when c_lo=1.
REQ-024 A new grant SHALL be possible no earlier than the cycle after the result handshake.
REQ-025 Requests SHALL be ignored, with no gnt, outside IDLE; a requester holds req and its operands until its gnt.
REQ-026 Operand changes after the grant cycle SHALL NOT affect the result in progress.
REQ-027 res_ready asserted outside DONE SHALL have no effect.
REQ-028 gnt0 and gnt1 SHALL never be high in the same cycle.

Reset
REQ-029 While rst=1, the block SHALL immediately force state to IDLE and drive gnt0=gnt1=0, res_valid=0, res_id=0, res_sum=0, res_co=0 and add_n1=add_n2=0, asynchronously and regardless of clk.
REQ-030 Reset SHALL set the last-served pointer to 1, so req0 wins the first tie.
REQ-031 Reset asserted mid-operation, in LO, HI, INC or DONE, SHALL abort the operation with no result and no res_valid pulse.
REQ-032 The first grant SHALL be possible in the first clock edge after rst deasserts.

Verification
REQ-033 The bench SHALL drive req0 with a0=0x12 and b0=0x34 and res_ready=1, and check gnt0 pulse, then res_valid 3 cycles later, res_sum=0x46, res_co=0, res_id=0.
REQ-034 The bench SHALL drive req1 with a1=0x0F and b1=0x01, and check the INC path: res_valid 4 cycles after the grant, res_sum=0x10, res_co=0.
REQ-035 The bench SHALL apply a1=0xFF and b1=0x01, and check res_sum=0x00 and res_co=1 via INC carry; it SHALL also apply 0xF0+0x20 and check res_sum=0x10 and res_co=1 via the HI carry.
REQ-036 The bench SHALL hold req0 and req1 high continuously with FIXED_PRIO=0, and check the grants alternate 0,1,0,1; with FIXED_PRIO=1, it SHALL check the grants are always 0.
REQ-037 The bench SHALL hold res_ready=0 for 5 cycles in DONE, and check res_valid and res_sum stable, no new gnt, and IDLE one cycle after res_ready=1.
REQ-038 The bench SHALL assert rst in HI, and check all outputs are 0 at once, no res_valid follows, and req0 is granted on the first edge after release.

Source files
------------

// File: rtl/sum8_scheduler.sv
`default_nettype none
// ============================================================================
//  Module  : sum8_scheduler
//  Brief   : Two-requester 8-bit adder scheduler. Arbitrates between two
//            requesters, then computes a+b as two nibble passes through a
//            shared external 4-bit adder (no carry-in). A third "increment"
//            pass folds the low-nibble carry into the high nibble.
//  Rev     : 1.0  initial release
// ============================================================================
module sum8_scheduler #(
  parameter int FIXED_PRIO = 0   // 0: round-robin, 1: requester 0 always wins
) (
  input  logic       clk,
  input  logic       rst,
  // requesters
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  // result channel
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_id,
  output logic [7:0] res_sum,
  output logic       res_co,
  // shared external 4-bit adder
  output logic [3:0] add_n1,
  output logic [3:0] add_n2,
  input  logic [3:0] add_so,
  input  logic       add_co
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    INC  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_next;

  // Latched operation context
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic       r_id;
  // Partial results
  logic [7:0] r_sum;
  logic       r_c_lo;
  logic       r_c_hi;
  logic       r_co;
  // Round-robin pointer: index of the requester served most recently
  logic       r_last;

  // Arbitration / control
  logic       w_pick1;
  logic       w_gnt0;
  logic       w_gnt1;

  // Pick the winner assuming a grant is issued this cycle.
  always_comb begin
    w_pick1 = 1'b0;
    if (req0 && req1) begin
      // On a tie, round-robin serves whoever was not served last.
      w_pick1 = (FIXED_PRIO != 0) ? 1'b0 : ~r_last;
    end else begin
      w_pick1 = req1;
    end
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state, grant and adder-operand decode.
  always_comb begin
    w_next = r_state;
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    add_n1 = 4'd0;
    add_n2 = 4'd0;
    case (r_state)
      IDLE: begin
        // Grants are gated by rst so they drop immediately on reset even
        // though the request inputs are still high.
        if ((req0 || req1) && !rst) begin
          w_gnt0 = ~w_pick1;
          w_gnt1 = w_pick1;
          w_next = LO;
        end
      end
      LO: begin
        add_n1 = r_a[3:0];
        add_n2 = r_b[3:0];
        w_next = HI;
      end
      HI: begin
        add_n1 = r_a[7:4];
        add_n2 = r_b[7:4];
        // The adder has no carry-in, so a low-nibble carry needs an
        // extra pass that adds one to the high nibble.
        w_next = r_c_lo ? INC : DONE;
      end
      INC: begin
        add_n1 = r_sum[7:4];
        add_n2 = 4'b0001;
        w_next = DONE;
      end
      DONE: begin
        if (res_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Operand latching, nibble accumulation and round-robin pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= 8'd0;
      r_b    <= 8'd0;
      r_id   <= 1'b0;
      r_sum  <= 8'd0;
      r_c_lo <= 1'b0;
      r_c_hi <= 1'b0;
      r_co   <= 1'b0;
      r_last <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_a    <= w_gnt1 ? a1 : a0;
            r_b    <= w_gnt1 ? b1 : b0;
            r_id   <= w_gnt1;
            r_last <= w_gnt1;
          end
        end
        LO: begin
          r_sum[3:0] <= add_so;
          r_c_lo     <= add_co;
        end
        HI: begin
          r_sum[7:4] <= add_so;
          r_c_hi     <= add_co;
          // Without a low carry the high-nibble carry is the final carry.
          if (!r_c_lo) begin
            r_co <= add_co;
          end
        end
        INC: begin
          r_sum[7:4] <= add_so;
          r_co       <= r_c_hi | add_co;
        end
        default: begin
        end
      endcase
    end
  end

  assign gnt0      = w_gnt0;
  assign gnt1      = w_gnt1;
  assign res_valid = (r_state == DONE);
  assign res_id    = r_id;
  assign res_sum   = r_sum;
  assign res_co    = r_co;

endmodule
`default_nettype wire

// File: tb/tb_sum8_scheduler.sv
`default_nettype none
// ============================================================================
//  Module  : tb_sum8_scheduler
//  Brief   : Scoreboard bench for sum8_scheduler: directed corner cases plus
//            randomized two-requester traffic against a plain-arithmetic
//            reference model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_sum8_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [7:0] a0 = 8'd0;
  logic [7:0] b0 = 8'd0;
  logic [7:0] a1 = 8'd0;
  logic [7:0] b1 = 8'd0;
  logic       res_ready;
  logic       gnt0, gnt1, res_valid, res_id, res_co, add_co;
  logic [7:0] res_sum;
  logic [3:0] add_n1, add_n2, add_so;

  // second instance with fixed priority
  logic       f_req0 = 1'b0;
  logic       f_req1 = 1'b0;
  logic       f_gnt0, f_gnt1, f_valid, f_id, f_co, f_add_co;
  logic [7:0] f_sum;
  logic [3:0] f_n1, f_n2, f_so;

  int         rdy_mode = 0;      // 0: always ready, 1: random, 2: manual
  logic       rnd_rdy  = 1'b1;
  logic       man_rdy  = 1'b0;
  int         cyc      = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  assign res_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? rnd_rdy : man_rdy;

  // external 4-bit adders
  assign {add_co, add_so}   = {1'b0, add_n1} + {1'b0, add_n2};
  assign {f_add_co, f_so}   = {1'b0, f_n1} + {1'b0, f_n2};

  sum8_scheduler #(.FIXED_PRIO(0)) u_dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(gnt0), .gnt1(gnt1),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_sum(res_sum), .res_co(res_co), .add_n1(add_n1), .add_n2(add_n2),
    .add_so(add_so), .add_co(add_co)
  );

  sum8_scheduler #(.FIXED_PRIO(1)) u_dut_fixed (
    .clk(clk), .rst(rst), .req0(f_req0), .req1(f_req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(f_gnt0), .gnt1(f_gnt1),
    .res_valid(f_valid), .res_ready(1'b1), .res_id(f_id),
    .res_sum(f_sum), .res_co(f_co), .add_n1(f_n1), .add_n2(f_n2),
    .add_so(f_so), .add_co(f_add_co)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rnd_rdy = 1'($urandom_range(0, 1));
    end
  end

  typedef struct {
    logic       id;
    logic [7:0] sum;
    logic       co;
    int         lat;
    int         gcyc;
  } exp_t;

  exp_t pend0[$];
  exp_t pend1[$];
  exp_t infl[$];
  logic m_last     = 1'b1;
  logic prev_valid = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired (t=%0t)", nm, $time);
  endtask

  // Reference: plain 9-bit addition; extra cycle whenever the low nibbles carry.
  function automatic exp_t make_exp(input logic id, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   s;
    s      = int'(a) + int'(b);
    e.id   = id;
    e.sum  = 8'(s % 256);
    e.co   = (s >= 256);
    e.lat  = ((int'(a) % 16) + (int'(b) % 16) >= 16) ? 4 : 3;
    e.gcyc = 0;
    return e;
  endfunction

  task automatic push_exp(input logic id, input logic [7:0] a, input logic [7:0] b);
    if (id) pend1.push_back(make_exp(id, a, b));
    else    pend0.push_back(make_exp(id, a, b));
  endtask

  // Monitor / scoreboard for the round-robin instance.
  always @(negedge clk) begin
    exp_t h;
    logic w;
    logic expw;
    if (rst) begin
      infl.delete();
      m_last     = 1'b1;
      prev_valid = 1'b0;
      check("rst_res_valid", res_valid, 0);
    end else begin
      if (gnt0 || gnt1) begin
        w = gnt1;
        check("gnt_onehot", gnt0 & gnt1, 0);
        check("gnt_while_busy", infl.size(), 0);
        if (req0 && req1) expw = ~m_last;
        else              expw = req1;
        check("arb_winner", w, expw);
        m_last = w;
        if (w ? (pend1.size() == 0) : (pend0.size() == 0)) begin
          bound_fail("gnt_without_request");
        end else begin
          h = w ? pend1.pop_front() : pend0.pop_front();
          h.gcyc = cyc;
          infl.push_back(h);
        end
      end
      if (res_valid) begin
        if (infl.size() == 0) begin
          bound_fail("unexpected_res_valid");
        end else begin
          h = infl[0];
          if (!prev_valid) check("latency", cyc - h.gcyc, h.lat);
          check("res_id", res_id, h.id);
          check("res_sum", res_sum, h.sum);
          check("res_co", res_co, h.co);
          if (res_ready) void'(infl.pop_front());
        end
      end else if (infl.size() != 0 && (cyc - infl[0].gcyc) > 20) begin
        bound_fail("result_timeout");
        void'(infl.pop_front());
      end
      prev_valid = res_valid && !res_ready;
    end
  end

  task automatic wait_gnt(input logic id, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (id ? gnt1 : gnt0) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Issue one request; after the grant scramble operands, optionally keep
  // req high for a few cycles (no further grant may appear), then drop it.
  task automatic req_txn(input logic id, input logic [7:0] a, input logic [7:0] b, input int hold);
    logic ok;
    @(posedge clk);
    #1;
    push_exp(id, a, b);
    if (id) begin a1 = a; b1 = b; req1 = 1'b1; end
    else    begin a0 = a; b0 = b; req0 = 1'b1; end
    wait_gnt(id, ok);
    if (!ok) bound_fail("gnt_timeout");
    @(posedge clk);
    #1;
    if (id) begin a1 = 8'($urandom); b1 = 8'($urandom); end
    else    begin a0 = 8'($urandom); b0 = 8'($urandom); end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("no_gnt_outside_idle", id ? gnt1 : gnt0, 0);
      @(posedge clk);
      #1;
    end
    if (id) req1 = 1'b0;
    else    req0 = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (infl.size() == 0 && pend0.size() == 0 && pend1.size() == 0) return;
      @(negedge clk);
    end
    bound_fail("drain");
    infl.delete();
    pend0.delete();
    pend1.delete();
  endtask

  function automatic logic [7:0] rnd_op();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 8'hFF;
    if (r == 1) return 8'h00;
    return 8'($urandom);
  endfunction

  task automatic requester(input logic id, input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      req_txn(id, rnd_op(), rnd_op(), 0);
    end
  endtask

  initial begin
    int   seq[$];
    int   fg0;
    int   fg1;
    logic ok;
    fg0 = 0;
    fg1 = 0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_res_id", res_id, 0);
    check("rst_res_sum", res_sum, 0);
    check("rst_res_co", res_co, 0);
    check("rst_add_n1", add_n1, 0);
    check("rst_add_n2", add_n2, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // directed sums: plain, INC path, INC carry-out, HI carry-out
    req_txn(1'b0, 8'h12, 8'h34, 2);
    drain();
    req_txn(1'b1, 8'h0F, 8'h01, 1);
    drain();
    req_txn(1'b1, 8'hFF, 8'h01, 0);
    drain();
    req_txn(1'b0, 8'hF0, 8'h20, 0);
    drain();

    // back-pressure in DONE with a competing request waiting
    rdy_mode = 2;
    man_rdy  = 1'b0;
    req_txn(1'b0, 8'h77, 8'h11, 0);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = res_valid;
    end
    if (!ok) bound_fail("wait_done");
    #1;
    push_exp(1'b1, 8'h21, 8'h43);
    a1 = 8'h21; b1 = 8'h43; req1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", res_valid, 1);
      check("stall_sum", res_sum, 8'h88);
      check("stall_no_gnt", gnt1, 0);
    end
    @(posedge clk);
    #1;
    man_rdy = 1'b1;
    @(negedge clk);
    check("handshake_valid", res_valid, 1);
    @(negedge clk);
    check("idle_valid_low", res_valid, 0);
    check("idle_add_n1", add_n1, 0);
    check("idle_gnt1", gnt1, 1);
    @(posedge clk);
    #1;
    req1 = 1'b0; a1 = 8'($urandom); b1 = 8'($urandom);
    rdy_mode = 0; man_rdy = 1'b0;
    drain();

    // reset during HI
    @(posedge clk);
    #1;
    push_exp(1'b0, 8'h5A, 8'h3C);
    a0 = 8'h5A; b0 = 8'h3C; req0 = 1'b1;
    wait_gnt(1'b0, ok);
    if (!ok) bound_fail("gnt_timeout_hi");
    @(posedge clk);
    #1;
    req0 = 1'b0;
    @(posedge clk);
    #1;
    check("hi_add_n1", add_n1, 4'h5);
    check("hi_add_n2", add_n2, 4'h3);
    rst = 1'b1;
    #1;
    check("arst_gnt0", gnt0, 0);
    check("arst_gnt1", gnt1, 0);
    check("arst_res_valid", res_valid, 0);
    check("arst_res_id", res_id, 0);
    check("arst_res_sum", res_sum, 0);
    check("arst_res_co", res_co, 0);
    check("arst_add_n1", add_n1, 0);
    check("arst_add_n2", add_n2, 0);
    push_exp(1'b0, 8'h01, 8'h02);
    a0 = 8'h01; b0 = 8'h02; req0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("in_rst_gnt0", gnt0, 0);
      check("in_rst_valid", res_valid, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("first_gnt_after_rst", gnt0, 1);
    @(posedge clk);
    #1;
    req0 = 1'b0;
    drain();

    // both requests held: round-robin alternates, fixed priority stays on 0
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    a0 = 8'h12; b0 = 8'h34; a1 = 8'h0F; b1 = 8'h01;
    push_exp(1'b0, a0, b0); push_exp(1'b0, a0, b0);
    push_exp(1'b1, a1, b1); push_exp(1'b1, a1, b1);
    req0 = 1'b1; req1 = 1'b1; f_req0 = 1'b1; f_req1 = 1'b1;
    for (int i = 0; i < 120 && seq.size() < 4; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) seq.push_back(int'(gnt1));
      if (f_gnt0) fg0++;
      if (f_gnt1) fg1++;
      if (f_valid) begin
        check("fixed_sum", f_sum, 8'h46);
        check("fixed_id", f_id, 0);
        check("fixed_co", f_co, 0);
      end
    end
    @(posedge clk);
    #1;
    req0 = 1'b0; req1 = 1'b0; f_req0 = 1'b0; f_req1 = 1'b0;
    check("rr_grant_count", seq.size(), 4);
    foreach (seq[i]) check("rr_sequence", seq[i], i % 2);
    check("fixed_gnt1_count", fg1, 0);
    check("fixed_gnt0_seen", (fg0 >= 3), 1);
    drain();

    // randomized two-requester traffic with random back-pressure
    rdy_mode = 1;
    fork
      requester(1'b0, 25);
      requester(1'b1, 25);
    join
    drain();
    rdy_mode = 0;
    repeat (5) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
